// File: rtl/sr_latch_driver.sv
// Command front-end for an SR latch: turns set/reset requests into clean,
// non-overlapping s/r pulses with dead time and checks the latch feedback.
//
// state | meaning
// IDLE  | s=r=0, req_ready=1, waiting for a command
// PULSE | driving s (cmd=1) or r (cmd=0) for PULSE_W cycles
// DEAD  | s=r=0 for DEAD_W cycles, feedback sampled on the last edge
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int DEAD_W  = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_set,
  output logic             req_ready,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  input  logic             qn_fb,
  output logic             busy,
  output logic             exp_q,
  output logic             fault,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] cmd_cnt
);

  localparam int TMAX = (PULSE_W > DEAD_W) ? PULSE_W : DEAD_W;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] DEAD_LOAD  = TW'(DEAD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DEAD  = 2'd2
  } state_t;

  state_t        state;
  logic          cmd;
  logic [TW-1:0] tmr;
  logic          accept;
  logic          sample;
  logic          fb_bad;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;
  assign sample    = (state == DEAD) && (tmr == '0);

  // A healthy latch shows q == cmd with qn its complement; q == qn is never valid.
  assign fb_bad = (q_fb != cmd) | (qn_fb != ~cmd) | (q_fb == qn_fb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd     <= 1'b0;
      tmr     <= '0;
      s       <= 1'b0;
      r       <= 1'b0;
      exp_q   <= 1'b0;
      fault   <= 1'b0;
      cmd_cnt <= '0;
    end else begin
      // A new mismatch on the same edge as a clear keeps the flag set.
      if (fault_clr)
        fault <= 1'b0;
      if (sample && fb_bad)
        fault <= 1'b1;

      case (state)
        IDLE: begin
          s <= 1'b0;
          r <= 1'b0;
          if (accept) begin
            cmd     <= req_set;
            exp_q   <= req_set;
            cmd_cnt <= cmd_cnt + 1'b1;
            tmr     <= PULSE_LOAD;
            s       <= req_set;
            r       <= ~req_set;
            state   <= PULSE;
          end
        end
        PULSE: begin
          if (tmr == '0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            tmr   <= DEAD_LOAD;
            state <= DEAD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        DEAD: begin
          s <= 1'b0;
          r <= 1'b0;
          if (tmr == '0)
            state <= IDLE;
          else
            tmr <= tmr - 1'b1;
        end
        default: begin
          s     <= 1'b0;
          r     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Sequential command front-end that drives the s/r inputs of an sr_latch instance.
- Accepts set/reset commands over a valid/ready handshake and emits a clean pulse on s or r.
- Guarantees that s and r are never high together, and enforces a minimum pulse width and a dead time between pulses.
- Checks the latch's q/qn feedback after every pulse and raises a sticky fault flag on mismatch.

Parameters:
- PULSE_W, 4: cycles s or r is held high per command; legal range ≥1.
- DEAD_W, 2: idle cycles with s=r=0 after each pulse before the next command is accepted; legal range ≥1.
- CNT_W, 8: width of the accepted-command counter.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: command valid.
- req_set, input, 1: command type, 1 = set latch, 0 = reset latch; sampled with req_valid.
- req_ready, output, 1: driver can accept a command.
- s, output, 1: latch set drive, registered.
- r, output, 1: latch reset drive, registered.
- q_fb, input, 1: latch q feedback.
- qn_fb, input, 1: latch qn feedback.
- busy, output, 1: command in progress (not IDLE).
- exp_q, output, 1: expected latch state after the last accepted command.
- fault, output, 1: sticky feedback-mismatch flag.
- fault_clr, input, 1: clears fault.
- cmd_cnt, output, CNT_W: number of accepted commands, wraps.

Behaviour:
- Clock, reset and handshake:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on rst_n; all state is cleared immediately on assertion.
  - Reset values: s=0, r=0, exp_q=0, fault=0, cmd_cnt=0, state=IDLE, req_ready=1, busy=0.
  - Acceptance: req_valid && req_ready at a rising edge. req_ready = (state==IDLE), combinational from state only.
- States:
  - IDLE:
    - s=r=0.
    - On acceptance, latch req_set into cmd, set exp_q<=req_set, increment cmd_cnt (wraps at 2^CNT_W-1 → 0), load the counter with PULSE_W-1, go to PULSE.
  - PULSE:
    - s=cmd and r=~cmd, registered, so the pulse is high starting the cycle after acceptance.
    - Counter decrements each cycle; at 0, load the counter with DEAD_W-1 and go to DEAD.
    - s or r is high for exactly PULSE_W cycles.
  - DEAD:
    - s=r=0. Counter decrements each cycle.
    - At 0, sample q_fb/qn_fb at that edge. Mismatch is q_fb!=cmd, or qn_fb!=~cmd, or q_fb==qn_fb.
    - On mismatch, set fault. Go to IDLE.
- Timing:
  - Accept-to-accept minimum spacing is 1+PULSE_W+DEAD_W cycles; req_ready is low for PULSE_W+DEAD_W cycles.
  - fault is visible the cycle IDLE is re-entered.
- Invariant: s&&r is never 1 in any cycle, including across reset.
- Redundant commands (req_set==exp_q) still generate a full pulse and check.
- fault_clr:
  - Clears fault on the next edge.
  - If a new mismatch is detected in the same cycle, fault stays 1 (set wins).
  - fault_clr has no effect on the FSM.
- Reset mid-PULSE: s/r drop to 0 asynchronously; the command is discarded and not re-issued.
- req_set and req_valid are ignored while req_ready=0.
- Feedback is assumed stable at the DEAD sample point; it is not synchronised internally.

Test Plan:
- Defaults, set command: req_valid=1, req_set=1 for one cycle, latch model connected.
  - Required: s=1 for exactly 4 cycles starting the cycle after acceptance, then 2 cycles s=r=0.
  - Required: req_ready low for 6 cycles; exp_q=1, cmd_cnt=1, fault=0.
- Back-to-back set then reset with req_valid held high:
  - Required: second acceptance exactly 7 cycles after the first.
  - Required: r pulse of 4 cycles, q ends 0, no cycle with s&&r=1, cmd_cnt=2.
- Stuck feedback: tie q_fb=0, qn_fb=1, issue set.
  - Required: fault=1 on IDLE re-entry.
  - Required: assert fault_clr for one cycle → fault=0. Repeat with q_fb=qn_fb=1 → fault=1.
- Reset during PULSE: assert rst_n=0 on the 2nd s-high cycle.
  - Required: s=0 immediately without waiting for a clock edge; exp_q=0, cmd_cnt=0, req_ready=1.
  - Required: release reset → no pulse resumes.
- Counter wrap with CNT_W=2: issue 5 commands.
  - Required: cmd_cnt sequence 1, 2, 3, 0, 1.
- fault_clr coincident with a new mismatch at the DEAD sample edge:
  - Required: fault remains 1.
